// File: rtl/des_key_sched_if.sv
// Key-schedule handshake bundle: start/load side plus
// the valid/ready round-key stream toward PC-2.
interface des_key_sched_if #(
    parameter int HALF_W = 28,
    parameter int ROUNDS = 16
);
    localparam int KEY_W = 2 * HALF_W;
    localparam int IDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    logic             start;
    logic             mode;
    logic [KEY_W-1:0] key_in;
    logic             busy;
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] round_key;
    logic [IDX_W-1:0] round_idx;
    logic             last;

    modport master (
        output start,
        output mode,
        output key_in,
        output key_ready,
        input  busy,
        input  key_valid,
        input  round_key,
        input  round_idx,
        input  last
    );

    modport slave (
        input  start,
        input  mode,
        input  key_in,
        input  key_ready,
        output busy,
        output key_valid,
        output round_key,
        output round_idx,
        output last
    );
endinterface

// File: rtl/des_key_sched.sv
// DES-style key schedule: loads {C0,D0} and streams one
// rotated {Cn,Dn} per round, encrypt or reversed decrypt order.
module des_key_sched #(
    parameter int                HALF_W     = 28,
    parameter int                ROUNDS     = 16,
    parameter logic [ROUNDS-1:0] SHIFT_MASK = 16'h8103
) (
    input logic            clk,
    input logic            rst_n,
    des_key_sched_if.slave kif
);
    localparam int KEY_W = 2 * HALF_W;
    localparam int IDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    // Net rotation of a full encrypt schedule; decrypt starts here.
    function automatic int tot_shift();
        int sum;
        sum = 0;
        for (int r = 0; r < ROUNDS; r++) begin
            sum += SHIFT_MASK[r] ? 1 : 2;
        end
        return sum % HALF_W;
    endfunction

    localparam int TOT = tot_shift();

    function automatic logic [HALF_W-1:0] rotl(
        input logic [HALF_W-1:0] x,
        input int                n
    );
        logic [2*HALF_W-1:0] dbl;
        dbl = {x, x} << (n % HALF_W);
        return dbl[2*HALF_W-1 -: HALF_W];
    endfunction

    function automatic logic [HALF_W-1:0] rotr(
        input logic [HALF_W-1:0] x,
        input int                n
    );
        return rotl(x, HALF_W - (n % HALF_W));
    endfunction

    // one = 1 selects a single-bit step, otherwise two bits
    function automatic logic [HALF_W-1:0] step_l(
        input logic [HALF_W-1:0] x,
        input logic              one
    );
        return one ? rotl(x, 1) : rotl(x, 2);
    endfunction

    function automatic logic [HALF_W-1:0] step_r(
        input logic [HALF_W-1:0] x,
        input logic              one
    );
        return one ? rotr(x, 1) : rotr(x, 2);
    endfunction

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [HALF_W-1:0]   c_q, c_d;
    logic [HALF_W-1:0]   d_q, d_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;

    logic [IDX_W-1:0]    nxt_idx;
    logic [IDX_W-1:0]    dec_pos;
    logic [HALF_W-1:0]   c_in;
    logic [HALF_W-1:0]   d_in;

    assign c_in = kif.key_in[KEY_W-1 -: HALF_W];
    assign d_in = kif.key_in[HALF_W-1:0];

    // Next-state: load on start, advance one round per handshake.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        nxt_idx = idx_q + 1'b1;
        dec_pos = LAST_IDX - idx_q;
        unique case (state_q)
            IDLE: begin
                if (kif.start) begin
                    state_d = RUN;
                    mode_d  = kif.mode;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    last_d  = (ROUNDS == 1);
                    if (kif.mode) begin
                        c_d = rotl(c_in, TOT);
                        d_d = rotl(d_in, TOT);
                    end else begin
                        c_d = step_l(c_in, SHIFT_MASK[0]);
                        d_d = step_l(d_in, SHIFT_MASK[0]);
                    end
                end
            end
            RUN: begin
                if (valid_q && kif.key_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = nxt_idx;
                        last_d = (nxt_idx == LAST_IDX);
                        if (mode_q) begin
                            c_d = step_r(c_q, SHIFT_MASK[dec_pos]);
                            d_d = step_r(d_q, SHIFT_MASK[dec_pos]);
                        end else begin
                            c_d = step_l(c_q, SHIFT_MASK[nxt_idx]);
                            d_d = step_l(d_q, SHIFT_MASK[nxt_idx]);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial schedule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            c_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            c_q     <= c_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign kif.busy      = (state_q == RUN);
    assign kif.key_valid = valid_q;
    assign kif.round_key = {c_q, d_q};
    assign kif.round_idx = idx_q;
    assign kif.last      = last_q;
endmodule

// File: doc/des_key_sched.md
Name: des_key_sched

Overview:
- Sequential DES-style key-schedule generator. Successor to the single-step 28-bit half-key rotator.
- Loads the 2×HALF_W post-PC-1 key, then emits one rotated C‖D state per round over a valid/ready handshake.
- Supports an encrypt sequence (left rotates) and a decrypt sequence (exact reverse order, right rotates).
- Sits between the PC-1 stage and the PC-2 compression feeding the round datapath.

Parameters:
- HALF_W, 28, width of each key half C and D.
- ROUNDS, 16, number of round keys emitted per start.
- SHIFT_MASK, 16'h8103, bit r (0-indexed encrypt round r): 1 = rotate by 1, 0 = rotate by 2. Width ROUNDS.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  begin a schedule; sampled only in IDLE.
- mode  input  1  0 = encrypt order, 1 = decrypt order; sampled with start.
- key_in  input  2*HALF_W  {C0,D0}; sampled with start.
- busy  output  1  high while not IDLE.
- key_valid  output  1  round_key/round_idx valid.
- key_ready  input  1  consumer accepts when key_valid & key_ready.
- round_key  output  2*HALF_W  {Cn,Dn} for the current round.
- round_idx  output  $clog2(ROUNDS)  0..ROUNDS-1, output order index.
- last  output  1  key_valid & round_idx==ROUNDS-1.

Behaviour:
- Reset (async, rst_n low): state IDLE; busy=0; key_valid=0; round_key=0; round_idx=0; last=0. Takes effect immediately, including mid-schedule; the partial schedule is discarded.
- Shift amount: s(r) = SHIFT_MASK[r] ? 1 : 2. TOT = (sum of s(r) over all r) mod HALF_W, an elaboration-time constant (0 for DES defaults). Rotates apply independently to C and D.
- FSM states: IDLE, RUN.
- IDLE:
  - On start=1 at edge N, go to RUN. After edge N: key_valid=1, round_idx=0.
  - Encrypt (mode=0): round_key = {rotl(C0,s(0)), rotl(D0,s(0))}.
  - Decrypt (mode=1): round_key = {rotl(C0,TOT), rotl(D0,TOT)}, i.e. the final encrypt key.
  - start low: hold all outputs.
- RUN:
  - key_valid & !key_ready: round_key, round_idx and last held stable. No state change.
  - Handshake with round_idx=i < ROUNDS-1: round_idx=i+1 next cycle.
    - Encrypt: each half rotl by s(i+1).
    - Decrypt: each half rotr by s(ROUNDS-1-i), so the output at index i+1 equals encrypt key index ROUNDS-2-i.
  - Handshake with round_idx=ROUNDS-1: next cycle IDLE, key_valid=0, busy=0, round_idx=0. round_key keeps its last value.
- Latency: first key valid 1 cycle after start. With key_ready held high, ROUNDS keys arrive on consecutive cycles; busy is high for exactly ROUNDS cycles.
- start asserted while busy (including during the final handshake cycle): ignored. The next start is accepted from IDLE, so there is a minimum 1 idle cycle between schedules.
- mode and key_in are ignored except when start is accepted.
- Encrypt and decrypt sequences are exact mirrors for any SHIFT_MASK and HALF_W.
- No combinational path from key_ready to any output. All outputs are registered.

Test Plan:
- Reset mid-run: assert rst_n low at round_idx=7 -> outputs 0/IDLE immediately. Then start -> clean schedule beginning at round_idx=0.
- Encrypt, DES defaults, key_in=56'hF0CCAAF556678F, key_ready=1:
  - idx0 = E19955FAACCF1E.
  - idx1 = C33AABF5599E3D.
  - idx15 = F0CCAAF556678F, with last=1.
  - busy high for 16 cycles.
- Decrypt, same key:
  - idx0 = F0CCAAF556678F.
  - idx1 = F866557AAB33C7.
  - idx15 = E19955FAACCF1E.
  - Full output list equals the encrypt list reversed.
- Backpressure: toggle key_ready randomly, hold low 5 cycles at idx3 -> round_key and idx stable throughout. Still exactly 16 transfers, in order, with no repeats or skips.
- start while busy: pulse start with a different key at idx5 -> ignored, sequence unchanged. start in the final-handshake cycle -> ignored. start one cycle later -> accepted.
- Parameter sweep: HALF_W=8, ROUNDS=4, SHIFT_MASK=4'b0101, key_in=16'h8001.
  - Encrypt sequence vs. golden model.
  - TOT=6 pre-rotation; decrypt sequence equals encrypt sequence reversed.
